// File: rtl/display_pkg.sv
// Shared types and seven-segment patterns for the multiplexed counter display.
// Patterns are active-high with bit 6..0 = segments a..g.
package display_pkg;

  typedef logic [3:0] digit_t;

  localparam logic [6:0] SEG_0     = 7'h7E;
  localparam logic [6:0] SEG_1     = 7'h30;
  localparam logic [6:0] SEG_2     = 7'h6D;
  localparam logic [6:0] SEG_3     = 7'h79;
  localparam logic [6:0] SEG_4     = 7'h33;
  localparam logic [6:0] SEG_5     = 7'h5B;
  localparam logic [6:0] SEG_6     = 7'h5F;
  localparam logic [6:0] SEG_7     = 7'h70;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h7B;
  localparam logic [6:0] SEG_BLANK = 7'h00;

endpackage

// File: rtl/seg7_decoder.sv
// BCD to active-high seven-segment pattern; codes above 9 and blank requests go dark.
module seg7_decoder
  import display_pkg::*;
(
  input  digit_t     bcd_in,
  input  logic       blank_in,
  output logic [6:0] seg_out
);

  always_comb begin
    seg_out = SEG_BLANK;
    if (!blank_in) begin
      case (bcd_in)
        4'd0:    seg_out = SEG_0;
        4'd1:    seg_out = SEG_1;
        4'd2:    seg_out = SEG_2;
        4'd3:    seg_out = SEG_3;
        4'd4:    seg_out = SEG_4;
        4'd5:    seg_out = SEG_5;
        4'd6:    seg_out = SEG_6;
        4'd7:    seg_out = SEG_7;
        4'd8:    seg_out = SEG_8;
        4'd9:    seg_out = SEG_9;
        default: seg_out = SEG_BLANK;
      endcase
    end
  end

endmodule

// File: rtl/multiplexed_display.sv
// Cascaded modulo-RADIX event counter driving a time-multiplexed seven-segment display.
// Counter, scan prescaler and registered output stage share one clock domain.
module multiplexed_display
  import display_pkg::*;
#(
  parameter int DIGITS             = 4,
  parameter int RADIX              = 10,
  parameter int REFRESH_DIV        = 6750,
  parameter int BLANK_CYCLES       = 16,
  parameter int INVERT_SEGMENT_OUT = 1,
  parameter int INVERT_DIGIT_OUT   = 1,
  parameter int LEADING_ZERO_BLANK = 0
) (
  input  logic                  clkIn,
  input  logic                  resetNIn,
  input  logic                  clearIn,
  input  logic                  incrementIn,
  input  logic                  holdIn,
  input  logic [DIGITS-1:0]     dotIn,
  output logic [7:0]            segmentEnableOut,
  output logic [DIGITS-1:0]     digitEnableOut,
  output logic [4*DIGITS-1:0]   valueOut,
  output logic                  overflowOut
);

  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int PRE_W = $clog2(REFRESH_DIV);

  localparam digit_t            DIGIT_MAX = digit_t'(RADIX - 1);
  localparam logic [7:0]        SEG_OFF   = (INVERT_SEGMENT_OUT != 0) ? 8'hFF : 8'h00;
  localparam logic [DIGITS-1:0] DIG_OFF   = (INVERT_DIGIT_OUT != 0) ? {DIGITS{1'b1}} : '0;

  digit_t             digit_q [DIGITS];
  digit_t             digit_d [DIGITS];
  logic               inc_prev_q, inc_prev_d;
  logic               overflow_q, overflow_d;
  logic [PRE_W-1:0]   presc_q, presc_d;
  logic [IDX_W-1:0]   scan_q, scan_d;
  logic [7:0]         seg_q, seg_d;
  logic [DIGITS-1:0]  dig_q, dig_d;

  logic               inc_event;
  logic               carry;
  logic               all_max;

  // Counter: ripple-carry across digits, clear wins over increment.
  always_comb begin
    inc_event  = incrementIn && !inc_prev_q && !holdIn && !clearIn;
    inc_prev_d = incrementIn;
    carry      = inc_event;
    all_max    = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      digit_d[i] = digit_q[i];
      if (digit_q[i] != DIGIT_MAX) all_max = 1'b0;
      if (carry) begin
        if (digit_q[i] == DIGIT_MAX) begin
          digit_d[i] = '0;
        end else begin
          digit_d[i] = digit_q[i] + 4'd1;
          carry      = 1'b0;
        end
      end
      if (clearIn) digit_d[i] = '0;
    end
    overflow_d = inc_event && all_max;
  end

  always_comb begin
    valueOut = '0;
    for (int i = 0; i < DIGITS; i++) valueOut[4*i +: 4] = digit_q[i];
  end

  logic presc_wrap;

  always_comb begin
    presc_wrap = (presc_q == PRE_W'(REFRESH_DIV - 1));
    presc_d    = presc_wrap ? '0 : presc_q + 1'b1;
    scan_d     = scan_q;
    if (presc_wrap) scan_d = (scan_q == IDX_W'(DIGITS - 1)) ? '0 : scan_q + 1'b1;
  end

  digit_t     scan_digit;
  logic       scan_dot;
  logic       lz_blank;
  logic       nonzero_above;
  logic [6:0] pattern;

  // Scan multiplexer; a digit is blanked only if it and everything above it is zero.
  always_comb begin
    scan_digit    = '0;
    scan_dot      = 1'b0;
    nonzero_above = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (scan_q == IDX_W'(i)) begin
        scan_digit = digit_q[i];
        scan_dot   = dotIn[i];
      end
      if ((i >= int'(scan_q)) && (digit_q[i] != '0)) nonzero_above = 1'b1;
    end
    lz_blank = (LEADING_ZERO_BLANK != 0) && (scan_q != '0) && !nonzero_above;
  end

  seg7_decoder u_decoder (
    .bcd_in   (scan_digit),
    .blank_in (lz_blank),
    .seg_out  (pattern)
  );

  logic              in_dead_time;
  logic [DIGITS-1:0] dig_raw;
  logic [7:0]        seg_raw;

  always_comb begin
    in_dead_time = (presc_q < PRE_W'(BLANK_CYCLES));
    for (int i = 0; i < DIGITS; i++) dig_raw[i] = !in_dead_time && (scan_q == IDX_W'(i));
    seg_raw = {pattern, scan_dot};
    dig_d   = (INVERT_DIGIT_OUT != 0) ? ~dig_raw : dig_raw;
    seg_d   = (INVERT_SEGMENT_OUT != 0) ? ~seg_raw : seg_raw;
  end

  always_ff @(posedge clkIn or negedge resetNIn) begin
    if (!resetNIn) begin
      for (int i = 0; i < DIGITS; i++) digit_q[i] <= '0;
      inc_prev_q <= 1'b1;
      overflow_q <= 1'b0;
      presc_q    <= '0;
      scan_q     <= '0;
      seg_q      <= SEG_OFF;
      dig_q      <= DIG_OFF;
    end else begin
      for (int i = 0; i < DIGITS; i++) digit_q[i] <= digit_d[i];
      inc_prev_q <= inc_prev_d;
      overflow_q <= overflow_d;
      presc_q    <= presc_d;
      scan_q     <= scan_d;
      seg_q      <= seg_d;
      dig_q      <= dig_d;
    end
  end

  assign segmentEnableOut = seg_q;
  assign digitEnableOut   = dig_q;
  assign overflowOut      = overflow_q;

endmodule

// File: tb/tb_multiplexed_display.sv
// Bench for multiplexed_display: integer-count model checked every cycle plus directed literal checks.
module tb_multiplexed_display;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        clr = 1'b0;
  logic        inc = 1'b0;
  logic        hold = 1'b0;
  logic [3:0]  dot = 4'b0000;

  logic [7:0]  seg0, seg1;
  logic [3:0]  dig0, dig1;
  logic [15:0] val0, val1;
  logic        ovf0, ovf1;

  always #5 clk = ~clk;

  multiplexed_display #(
    .DIGITS(4), .RADIX(10), .REFRESH_DIV(8), .BLANK_CYCLES(2),
    .INVERT_SEGMENT_OUT(1), .INVERT_DIGIT_OUT(1), .LEADING_ZERO_BLANK(0)
  ) u_dut (
    .clkIn(clk), .resetNIn(rstn), .clearIn(clr), .incrementIn(inc), .holdIn(hold),
    .dotIn(dot), .segmentEnableOut(seg0), .digitEnableOut(dig0), .valueOut(val0),
    .overflowOut(ovf0)
  );

  multiplexed_display #(
    .DIGITS(4), .RADIX(10), .REFRESH_DIV(8), .BLANK_CYCLES(2),
    .INVERT_SEGMENT_OUT(1), .INVERT_DIGIT_OUT(1), .LEADING_ZERO_BLANK(1)
  ) u_dut_lz (
    .clkIn(clk), .resetNIn(rstn), .clearIn(clr), .incrementIn(inc), .holdIn(hold),
    .dotIn(dot), .segmentEnableOut(seg1), .digitEnableOut(dig1), .valueOut(val1),
    .overflowOut(ovf1)
  );

  int checks = 0;
  int errors = 0;
  logic mon_en = 1'b0;
  int ovf_cnt = 0;

  logic [6:0] seg_tbl [10] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33,
                               7'h5B, 7'h5F, 7'h70, 7'h7F, 7'h7B};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int pow10(input int n);
    int p = 1;
    for (int k = 0; k < n; k++) p = p * 10;
    return p;
  endfunction

  function automatic logic [15:0] to_bcd(input int c);
    logic [15:0] r = '0;
    for (int k = 0; k < 4; k++) r[4*k +: 4] = 4'((c / pow10(k)) % 10);
    return r;
  endfunction

  function automatic logic [3:0] exp_dig(input int t);
    int ph = t % 8;
    int idx = (t / 8) % 4;
    logic [3:0] onehot = 4'b0001;
    if (ph < 2) return 4'hF;
    return ~(onehot << idx);
  endfunction

  function automatic logic [7:0] exp_seg(input int c, input int t, input logic [3:0] d, input bit lzb);
    int idx = (t / 8) % 4;
    int p = pow10(idx);
    logic [6:0] pat;
    pat = (lzb && idx > 0 && c < p) ? 7'h00 : seg_tbl[(c / p) % 10];
    return ~{pat, d[idx]};
  endfunction

  // Model: count as a plain integer, time as cycles since reset release.
  int         cnt_m, t_m;
  logic       prev_m, ovf_m;
  logic [3:0] dig_m;
  logic [7:0] seg0_m, seg1_m;
  wire        ev_m = inc && !prev_m && !hold && !clr;

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt_m <= 0; t_m <= 0; prev_m <= 1'b1; ovf_m <= 1'b0;
      dig_m <= 4'hF; seg0_m <= 8'hFF; seg1_m <= 8'hFF;
    end else begin
      ovf_m  <= ev_m && (cnt_m == 9999);
      cnt_m  <= clr ? 0 : (ev_m ? (cnt_m + 1) % 10000 : cnt_m);
      prev_m <= inc;
      t_m    <= t_m + 1;
      dig_m  <= exp_dig(t_m);
      seg0_m <= exp_seg(cnt_m, t_m, dot, 1'b0);
      seg1_m <= exp_seg(cnt_m, t_m, dot, 1'b1);
    end
  end

  always @(negedge clk) begin
    if (ovf0) ovf_cnt <= ovf_cnt + 1;
    if (mon_en) begin
      chk("model_value", 32'(val0), 32'(to_bcd(cnt_m)));
      chk("model_value_lz", 32'(val1), 32'(to_bcd(cnt_m)));
      chk("model_overflow", 32'(ovf0), 32'(ovf_m));
      chk("model_overflow_lz", 32'(ovf1), 32'(ovf_m));
      chk("model_digit_en", 32'(dig0), 32'(dig_m));
      chk("model_digit_en_lz", 32'(dig1), 32'(dig_m));
      chk("model_segments", 32'(seg0), 32'(seg0_m));
      chk("model_segments_lz", 32'(seg1), 32'(seg1_m));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse();
    inc = 1'b1;
    tick();
    inc = 1'b0;
    tick();
  endtask

  // Reset is released just after an edge, then 32 cycles are sampled.
  task automatic scan_window(output int act [4], output int first, output int multi,
                             output logic [7:0] cap [4]);
    for (int i = 0; i < 4; i++) begin act[i] = 0; cap[i] = 8'h00; end
    first = -1;
    multi = 0;
    for (int k = 1; k <= 32; k++) begin
      tick();
      if (dig0 != 4'hF && first < 0) first = k;
      if ($countones(~dig0) > 1) multi++;
      for (int i = 0; i < 4; i++) if (!dig0[i]) begin act[i]++; cap[i] = seg1; end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int act [4];
    int first, multi, ovf_before;
    logic [7:0] cap [4];

    rstn = 1'b0;
    repeat (3) tick();
    mon_en = 1'b1;
    chk("reset_value", 32'(val0), 32'h0);
    chk("reset_digit_en", 32'(dig0), 32'hF);
    chk("reset_segments", 32'(seg0), 32'hFF);
    chk("reset_overflow", 32'(ovf0), 32'h0);

    // Held-high increment through reset must not count.
    inc = 1'b1;
    rstn = 1'b1;
    scan_window(act, first, multi, cap);
    chk("scan_first_active", 32'(first), 32'd3);
    chk("scan_never_two", 32'(multi), 32'd0);
    for (int i = 0; i < 4; i++) chk("scan_active_cycles", 32'(act[i]), 32'd6);
    chk("inc_high_through_reset", 32'(val0), 32'h0);
    inc = 1'b0;
    tick();

    ovf_before = ovf_cnt;
    repeat (123) pulse();
    chk("count_123", 32'(val0), 32'h0123);
    chk("no_ovf_123", 32'(ovf_cnt - ovf_before), 32'd0);

    inc = 1'b1;
    repeat (20) tick();
    inc = 1'b0;
    tick();
    chk("held_high_one_count", 32'(val0), 32'h0124);

    hold = 1'b1; tick();
    inc = 1'b1; tick(); tick();
    hold = 1'b0; repeat (3) tick();
    inc = 1'b0; tick();
    chk("edge_in_hold_discarded", 32'(val0), 32'h0124);
    pulse();
    chk("count_after_hold", 32'(val0), 32'h0125);

    clr = 1'b1; tick(); clr = 1'b0;
    chk("clear", 32'(val0), 32'h0);
    repeat (9) pulse();
    chk("count_9", 32'(val0), 32'h0009);
    ovf_before = ovf_cnt;
    clr = 1'b1; inc = 1'b1; tick();
    chk("clear_beats_increment", 32'(val0), 32'h0);
    clr = 1'b0; inc = 1'b0; tick(); tick();
    chk("clear_no_overflow", 32'(ovf_cnt - ovf_before), 32'd0);

    repeat (40) pulse();
    chk("count_40", 32'(val1), 32'h0040);
    dot = 4'b1000;
    tick();
    scan_window(act, first, multi, cap);
    chk("lz_digit3_dot_only", 32'(cap[3]), 32'hFE);
    chk("lz_digit2_blank", 32'(cap[2]), 32'hFF);
    chk("lz_digit1_four", 32'(cap[1]), 32'h99);
    chk("lz_digit0_zero", 32'(cap[0]), 32'h03);
    dot = 4'b0000;

    clr = 1'b1; tick(); clr = 1'b0;
    repeat (9999) pulse();
    chk("count_9999", 32'(val0), 32'h9999);
    ovf_before = ovf_cnt;
    inc = 1'b1; tick();
    chk("wrap_value", 32'(val0), 32'h0);
    chk("wrap_overflow_high", 32'(ovf0), 32'h1);
    inc = 1'b0; tick();
    chk("wrap_overflow_low", 32'(ovf0), 32'h0);
    tick();
    chk("wrap_overflow_once", 32'(ovf_cnt - ovf_before), 32'd1);

    repeat (57) pulse();
    chk("count_57", 32'(val0), 32'h0057);
    rstn = 1'b0;
    #1;
    chk("midrun_reset_value", 32'(val0), 32'h0);
    chk("midrun_reset_digit_en", 32'(dig0), 32'hF);
    chk("midrun_reset_segments", 32'(seg0), 32'hFF);
    tick(); tick();
    rstn = 1'b1;
    scan_window(act, first, multi, cap);
    chk("midrun_first_active", 32'(first), 32'd3);

    mon_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/multiplexed_display.md
MULTIPLEXED_DISPLAY -- requirements
Module: multiplexed_display

Interface
REQ-001 Parameter DIGITS, default 4, number of cascaded digits and scanned display positions (1..8).
REQ-002 Parameter RADIX, default 10, modulo of each digit (2..10).
REQ-003 Parameter REFRESH_DIV, default 6750, clkIn cycles per digit scan slot (>= 4).
REQ-004 Parameter BLANK_CYCLES, default 16, anti-ghosting dead time at the start of each slot (< REFRESH_DIV).
REQ-005 Parameter INVERT_SEGMENT_OUT, default 1, segment and dot outputs active-low when 1.
REQ-006 Parameter INVERT_DIGIT_OUT, default 1, digit enables active-low when 1.
REQ-007 Parameter LEADING_ZERO_BLANK, default 0, suppresses leading zeros when 1.
REQ-008 clkIn  input  1  single system clock; all logic on its rising edge.
REQ-009 resetNIn  input  1  reset, asynchronous, active-low.
REQ-010 clearIn  input  1  synchronous clear of all digits.
REQ-011 incrementIn  input  1  count request, synchronous to clkIn, already debounced; rising edge counts.
REQ-012 holdIn  input  1  freezes the count while high.
REQ-013 dotIn  input  DIGITS  decimal point request per digit, bit i = digit i.
REQ-014 segmentEnableOut  output  8  bit 7..1 = segments a..g, bit 0 = dot, for the digit currently scanned.
REQ-015 digitEnableOut  output  DIGITS  one-hot digit select, bit i = digit i.
REQ-016 valueOut  output  4*DIGITS  packed count, digit i in bits 4i+3..4i, digit 0 least significant.
REQ-017 overflowOut  output  1  single-cycle pulse on full-chain wrap.

Function
REQ-018 An increment event SHALL be incrementIn high with its registered previous value low, holdIn low and clearIn low; valueOut SHALL update on that same clock edge.
REQ-019 Increment: digit 0 SHALL advance by one; digit i SHALL advance only when every lower digit equals RADIX-1; a digit at RADIX-1 that advances SHALL wrap to 0.
REQ-020 When all digits equal RADIX-1 at an increment event, all digits SHALL wrap to 0 and overflowOut SHALL be high for exactly the following cycle.
REQ-021 clearIn SHALL set all digits to 0 on the next edge, take priority over increment, and produce no overflow pulse.
REQ-022 A rising edge of incrementIn occurring while holdIn is high SHALL be discarded, not deferred.
REQ-023 A prescaler SHALL count 0..REFRESH_DIV-1 and wrap; on wrap the scan index SHALL advance, wrapping DIGITS-1 to 0.
REQ-024 During prescaler values 0..BLANK_CYCLES-1 all digit enables SHALL be at their inactive level; otherwise exactly the scanned index SHALL be active.
REQ-025 segmentEnableOut SHALL carry the decoded pattern of the scanned digit (0..9 standard, a..g active-high before inversion) and dotIn of that index in bit 0.
REQ-026 With LEADING_ZERO_BLANK=1, digit i>0 SHALL show all segments off when it and every higher digit are 0; digit 0 is never blanked; the dot is unaffected.
REQ-027 segmentEnableOut and digitEnableOut SHALL be registered, lagging prescaler/index by one cycle, and change together glitch-free.
REQ-028 Polarity SHALL be applied at the output registers: inverted when the respective INVERT parameter is 1.

Reset
REQ-029 On resetNIn low: all digits 0, scan index 0, prescaler 0, overflowOut 0, digit enables and segments at inactive level, previous-increment register 1 (an input held high through reset does not count).
REQ-030 Reset asserted mid-scan or mid-carry SHALL abort immediately; after release, the first active digit enable SHALL appear BLANK_CYCLES+1 cycles later.

Structure
REQ-031 Package display_pkg SHALL hold the 7-bit segment pattern constants for 0..9, the blank pattern, and the digit type (4-bit BCD).
REQ-032 Decoding SHALL live in sub-module seg7_decoder (BCD in, blank in, 7-bit active-high pattern out); one instance, driven by the scan multiplexer.

Verification (DIGITS=4, RADIX=10, REFRESH_DIV=8, BLANK_CYCLES=2)
REQ-033 After reset, 123 single-cycle increment pulses -> valueOut = 0x0123, overflowOut never high.
REQ-034 Preset to 9999 via 9999 pulses, one more pulse -> valueOut = 0x0000 next cycle, overflowOut high exactly one cycle.
REQ-035 incrementIn held high 20 cycles -> exactly one count; rising edge with holdIn high -> no count after hold drops.
REQ-036 clearIn and increment edge in same cycle at 0x0009 -> valueOut = 0x0000, no overflow pulse.
REQ-037 Scan over 32 cycles -> each digit enable active 6 of each 8-cycle slot, in order 0,1,2,3, never two active; segments match digit value with inversion.
REQ-038 LEADING_ZERO_BLANK=1, value 0x0040, dotIn=4'b1000 -> digit 3 segments off but dot lit, digit 2 blank, digit 1 shows 4, digit 0 shows 0.
